// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: accepts one word address per request, reads the
// program array after LAT cycles and holds the word until the response handshake.
module instr_mem_responder #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [ADDR_W-1:0] resp_addr,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              busy
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [2:0] CNT_LAST = 3'(LAT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_reg;
   logic [2:0]        cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] rd_words [DEPTH];
   logic              accept;

   // A load in the same cycle wins over a request; ready is forced low while in reset.
   assign req_ready = rst_n & (state_reg == IDLE) & ~load_en;
   assign accept    = req_valid & req_ready;
   assign busy      = (state_reg != IDLE);

   // Each word is its own register so the whole array can be cleared by reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DATA_W-1:0] word_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               word_reg <= '0;
            end else if (load_en && (load_addr == ADDR_W'(gi))) begin
               word_reg <= load_data;
            end
         end

         assign rd_words[gi] = word_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         addr_reg   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_addr  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  addr_reg  <= req_addr;
                  cnt_reg   <= '0;
                  state_reg <= ACCESS;
               end
            end
            ACCESS: begin
               cnt_reg <= cnt_reg + 3'd1;
               // Reads the pre-edge array contents, so a load on this same edge is not seen.
               if (cnt_reg == CNT_LAST) begin
                  resp_data  <= rd_words[addr_reg];
                  resp_addr  <= addr_reg;
                  resp_valid <= 1'b1;
                  state_reg  <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
